// File: rtl/booth_wallace_mul_pipe.sv
// Three-stage pipelined radix-4 Booth / Wallace-tree multiplier for MUL.W, MULH.W and MULH.WU.
// Stage 1 Booth-encodes the operands into partial-product rows. Stage 2 reduces them with
// full-adder levels to a sum row and a carry row. Stage 3 does the carry-propagate add and
// selects the requested half.
module booth_wallace_mul_pipe #(
  parameter int unsigned WIDTH = 32,  // even, >= 4
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  // Number of 3:2 levels needed to bring a stack of rows down to two.
  function automatic int unsigned tree_levels(input int unsigned rows);
    int unsigned r;
    int unsigned l;
    r = rows;
    l = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + r % 3;
      l++;
    end
    return l;
  endfunction

  localparam int unsigned ExtW    = WIDTH + 2;       // extended operand width
  localparam int unsigned NumPp   = ExtW / 2;        // Booth partial products
  localparam int unsigned ProdW   = 2 * WIDTH;       // full product width
  localparam int unsigned NumRows = NumPp + 1;       // partial products plus correction row
  localparam int unsigned NumLvl  = tree_levels(NumRows);

  // ---------------------------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s3_valid_q, s3_valid_d;
  logic s1_free, s2_free, s3_free;
  logic accept, s1_fire, s2_fire;

  // A stage can take new data when it is empty or its content moves on this cycle.
  assign s3_free  = !s3_valid_q || out_ready;
  assign s2_free  = !s2_valid_q || s3_free;
  assign s1_free  = !s1_valid_q || s2_free;
  assign in_ready = !flush && s1_free;
  assign accept   = in_valid && in_ready;
  assign s1_fire  = s1_valid_q && s2_free;
  assign s2_fire  = s2_valid_q && s3_free;

  assign out_valid = s3_valid_q;

  // Next-state of the stage valid bits; flush empties every stage.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s3_valid_d = s3_valid_q;
    if (s1_free) s1_valid_d = in_valid;
    if (s2_free) s2_valid_d = s1_valid_q;
    if (s3_free) s3_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      s3_valid_d = 1'b0;
    end
  end

  // Stage valid registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 1: operand extension and radix-4 Booth encoding
  // ---------------------------------------------------------------------------------------------
  logic             op_signed, op_high;
  logic [ExtW-1:0]  a_ext, b_ext;
  logic [ExtW:0]    b_pad;
  logic [ProdW-1:0] a_sx, a2_sx;
  logic [ProdW-1:0] pp_row [NumPp];
  logic [NumPp-1:0] pp_neg;

  // Op 11 behaves as op 00: zero-extended, low half.
  assign op_signed = (in_op == 2'b01);
  assign op_high   = (in_op == 2'b01) || (in_op == 2'b10);

  assign a_ext = op_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
  assign b_ext = op_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
  assign b_pad = {b_ext, 1'b0};  // implicit zero below bit 0
  assign a_sx  = {{(ProdW - ExtW){a_ext[ExtW-1]}}, a_ext};
  assign a2_sx = {a_sx[ProdW-2:0], 1'b0};

  // Booth row selection; a negative row is ~magnitude, with the +1 kept as a separate bit.
  always_comb begin
    logic [2:0]       grp;
    logic [ProdW-1:0] mag;
    logic             neg;
    pp_row = '{default: '0};
    pp_neg = '0;
    for (int i = 0; i < int'(NumPp); i++) begin
      grp = b_pad[2*i +: 3];
      mag = '0;
      neg = 1'b0;
      case (grp)
        3'b001, 3'b010: mag = a_sx;
        3'b011:         mag = a2_sx;
        3'b100: begin
          mag = a2_sx;
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          mag = a_sx;
          neg = 1'b1;
        end
        default: ;
      endcase
      pp_row[i] = (neg ? ~mag : mag) << (2 * i);
      pp_neg[i] = neg;
    end
  end

  logic [ProdW-1:0] s1_row_q [NumPp];
  logic [NumPp-1:0] s1_neg_q;
  logic             s1_high_q;
  logic [TAG_W-1:0] s1_tag_q;

  // Stage 1 datapath register, loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_row_q  <= pp_row;
      s1_neg_q  <= pp_neg;
      s1_high_q <= op_high;
      s1_tag_q  <= in_tag;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 2: Wallace reduction with full adders
  // ---------------------------------------------------------------------------------------------
  logic [ProdW-1:0] csa_sum, csa_carry;

  // Each level feeds rows to full adders three at a time and passes the 1-2 leftovers through.
  // Row counts depend only on WIDTH, so the loops unroll into a fixed adder tree.
  always_comb begin
    logic [ProdW-1:0] tree_work [NumRows];
    logic [ProdW-1:0] tree_next [NumRows];
    logic [ProdW-1:0] fa_a, fa_b, fa_c;
    int               cnt;
    int               nfa;
    tree_work = '{default: '0};
    tree_next = '{default: '0};
    fa_a      = '0;
    fa_b      = '0;
    fa_c      = '0;
    for (int i = 0; i < int'(NumPp); i++) begin
      tree_work[i]            = s1_row_q[i];
      tree_work[NumPp][2*i]   = s1_neg_q[i];  // Booth +1 corrections at each row's LSB
    end
    cnt = int'(NumRows);
    for (int lv = 0; lv < int'(NumLvl); lv++) begin
      tree_next = '{default: '0};
      nfa = cnt / 3;
      for (int j = 0; j < int'(NumRows / 3); j++) begin
        if (j < nfa) begin
          fa_a             = tree_work[3*j];
          fa_b             = tree_work[3*j+1];
          fa_c             = tree_work[3*j+2];
          tree_next[2*j]   = fa_a ^ fa_b ^ fa_c;
          tree_next[2*j+1] = ((fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c)) << 1;
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (r < cnt % 3) tree_next[2*nfa+r] = tree_work[3*nfa+r];
      end
      cnt       = 2 * nfa + cnt % 3;
      tree_work = tree_next;
    end
    csa_sum   = tree_work[0];
    csa_carry = tree_work[1];
  end

  logic [ProdW-1:0] s2_sum_q, s2_carry_q;
  logic             s2_high_q;
  logic [TAG_W-1:0] s2_tag_q;

  // Stage 2 datapath register.
  always_ff @(posedge clk) begin
    if (s1_fire) begin
      s2_sum_q   <= csa_sum;
      s2_carry_q <= csa_carry;
      s2_high_q  <= s1_high_q;
      s2_tag_q   <= s1_tag_q;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 3: carry-propagate add and half selection
  // ---------------------------------------------------------------------------------------------
  logic [ProdW-1:0] product;
  logic [WIDTH-1:0] result_sel;

  assign product    = s2_sum_q + s2_carry_q;
  assign result_sel = s2_high_q ? product[ProdW-1:WIDTH] : product[WIDTH-1:0];

  logic [WIDTH-1:0] out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  // Output register; held while the consumer stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (s2_fire) begin
      out_result_q <= result_sel;
      out_tag_q    <= s2_tag_q;
    end
  end

  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule
